// File: rtl/sid_bus_ctrl.sv
// sid_bus_ctrl: 6581 host-bus front end and register file.
// Syncs the async host bus into clk, decodes registers, drives voice/filter config.
module sid_bus_ctrl #(
   parameter int DECAY_CYCLES = 2000000,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        phi2,
   input  logic        cs_n,
   input  logic        rw,
   input  logic [4:0]  addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  pot_x,
   input  logic [7:0]  pot_y,
   input  logic [7:0]  osc3,
   input  logic [7:0]  env3,
   output logic [47:0] freq,
   output logic [35:0] pw,
   output logic [23:0] control,
   output logic [47:0] adsr,
   output logic [10:0] fc,
   output logic [7:0]  res_filt,
   output logic [7:0]  mode_vol,
   output logic [2:0]  gate_rise,
   output logic [2:0]  gate_fall
);

   localparam int CW = $clog2(DECAY_CYCLES + 1);
   localparam logic [CW-1:0] DECAY_LOAD = CW'(DECAY_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   logic [15:0]   sync_q [SYNC_STAGES];
   logic [15:0]   bus_s;
   logic          phi2_d;
   logic          phi2_s;
   logic          cs_n_s;
   logic          rw_s;
   logic [4:0]    addr_s;
   logic [7:0]    din_s;
   logic          rise;
   logic          fall;
   logic          commit;
   logic [2:0]    vsel;
   logic [2:0]    slot;
   logic [7:0]    rd_val;
   logic          rd_live;
   state_t        state;
   logic [7:0]    bus_latch;
   logic [CW-1:0] decay_cnt;
   logic [15:0]   freq_r [3];
   logic [11:0]   pw_r [3];
   logic [7:0]    ctrl_r [3];
   logic [7:0]    ad_r [3];
   logic [7:0]    sr_r [3];

   // Synchronizer chain for all bus pins, plus one extra phi2 delay for edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         phi2_d <= 1'b0;
      end else begin
         sync_q[0] <= {phi2, cs_n, rw, addr, data_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         phi2_d <= sync_q[SYNC_STAGES-1][15];
      end
   end

   assign bus_s = sync_q[SYNC_STAGES-1];
   assign {phi2_s, cs_n_s, rw_s, addr_s, din_s} = bus_s;
   assign rise   = phi2_s & ~phi2_d;
   assign fall   = ~phi2_s & phi2_d;
   assign commit = (state == ACCESS) && fall && !cs_n_s && !rw_s;

   // Split a voice address into a one-hot voice select and a slot offset
   always_comb begin
      vsel = 3'b000;
      slot = 3'd7;
      unique case (1'b1)
         (addr_s <= 5'd6): begin
            vsel = 3'b001;
            slot = addr_s[2:0];
         end
         (addr_s inside {[5'd7:5'd13]}): begin
            vsel = 3'b010;
            slot = 3'(addr_s - 5'd7);
         end
         (addr_s inside {[5'd14:5'd20]}): begin
            vsel = 3'b100;
            slot = 3'(addr_s - 5'd14);
         end
         default: begin
            vsel = 3'b000;
            slot = 3'd7;
         end
      endcase
   end

   // Read mux: live inputs for the read-only block, bus latch elsewhere
   always_comb begin
      rd_val  = bus_latch;
      rd_live = 1'b1;
      unique case (addr_s)
         5'h19:   rd_val = pot_x;
         5'h1A:   rd_val = pot_y;
         5'h1B:   rd_val = osc3;
         5'h1C:   rd_val = env3;
         default: rd_live = 1'b0;
      endcase
   end

   // Bus cycle FSM, read data, and the decaying bus latch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         data_out  <= '0;
         data_oe   <= 1'b0;
         bus_latch <= '0;
         decay_cnt <= '0;
      end else begin
         if (decay_cnt != '0) begin
            decay_cnt <= decay_cnt - CW'(1);
            if (decay_cnt == CW'(1)) bus_latch <= '0;
         end
         unique case (state)
            IDLE: begin
               if (rise && !cs_n_s) begin
                  state <= ACCESS;
                  if (rw_s) begin
                     data_oe  <= 1'b1;
                     data_out <= rd_val;
                     if (rd_live) begin
                        bus_latch <= rd_val;
                        decay_cnt <= DECAY_LOAD;
                     end
                  end
               end
            end
            ACCESS: begin
               if (fall) begin
                  state   <= IDLE;
                  data_oe <= 1'b0;
                  if (!cs_n_s && !rw_s) begin
                     bus_latch <= din_s;
                     decay_cnt <= DECAY_LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Register file writes and per-voice gate edge pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int v = 0; v < 3; v++) begin
            freq_r[v] <= '0;
            pw_r[v]   <= '0;
            ctrl_r[v] <= '0;
            ad_r[v]   <= '0;
            sr_r[v]   <= '0;
         end
         fc        <= '0;
         res_filt  <= '0;
         mode_vol  <= '0;
         gate_rise <= '0;
         gate_fall <= '0;
      end else begin
         gate_rise <= '0;
         gate_fall <= '0;
         for (int v = 0; v < 3; v++) begin
            if (commit && vsel[v]) begin
               case (slot)
                  3'd0: freq_r[v][7:0]  <= din_s;
                  3'd1: freq_r[v][15:8] <= din_s;
                  3'd2: pw_r[v][7:0]    <= din_s;
                  3'd3: pw_r[v][11:8]   <= din_s[3:0];
                  3'd4: begin
                     ctrl_r[v]    <= din_s;
                     gate_rise[v] <= din_s[0] & ~ctrl_r[v][0];
                     gate_fall[v] <= ~din_s[0] & ctrl_r[v][0];
                  end
                  3'd5: ad_r[v] <= din_s;
                  3'd6: sr_r[v] <= din_s;
                  default: ;
               endcase
            end
         end
         if (commit) begin
            case (addr_s)
               5'h15:   fc[2:0]  <= din_s[2:0];
               5'h16:   fc[10:3] <= din_s;
               5'h17:   res_filt <= din_s;
               5'h18:   mode_vol <= din_s;
               default: ;
            endcase
         end
      end
   end

   assign freq    = {freq_r[2], freq_r[1], freq_r[0]};
   assign pw      = {pw_r[2], pw_r[1], pw_r[0]};
   assign control = {ctrl_r[2], ctrl_r[1], ctrl_r[0]};
   assign adsr    = {ad_r[2], sr_r[2], ad_r[1], sr_r[1], ad_r[0], sr_r[0]};

endmodule

// File: tb/tb_sid_bus_ctrl.sv
// tb_sid_bus_ctrl: scoreboard bench for sid_bus_ctrl.
// Stimulus pushes cycle-tagged expected output snapshots; a monitor pops and compares.
module tb_sid_bus_ctrl;

   localparam int S     = 2;
   localparam int DECAY = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        phi2 = 1'b0;
   logic        cs_n = 1'b1;
   logic        rw = 1'b1;
   logic [4:0]  addr = '0;
   logic [7:0]  data_in = '0;
   logic [7:0]  pot_x = '0;
   logic [7:0]  pot_y = '0;
   logic [7:0]  osc3 = '0;
   logic [7:0]  env3 = '0;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [47:0] freq;
   logic [35:0] pw;
   logic [23:0] control;
   logic [47:0] adsr;
   logic [10:0] fc;
   logic [7:0]  res_filt;
   logic [7:0]  mode_vol;
   logic [2:0]  gate_rise;
   logic [2:0]  gate_fall;

   sid_bus_ctrl #(.DECAY_CYCLES(DECAY), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .phi2(phi2), .cs_n(cs_n), .rw(rw),
      .addr(addr), .data_in(data_in), .data_out(data_out),
      .data_oe(data_oe), .pot_x(pot_x), .pot_y(pot_y), .osc3(osc3),
      .env3(env3), .freq(freq), .pw(pw), .control(control),
      .adsr(adsr), .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol),
      .gate_rise(gate_rise), .gate_fall(gate_fall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [47:0] freq;
      logic [35:0] pw;
      logic [23:0] control;
      logic [47:0] adsr;
      logic [10:0] fc;
      logic [7:0]  res_filt;
      logic [7:0]  mode_vol;
      logic [2:0]  gate_rise;
      logic [2:0]  gate_fall;
      logic [7:0]  data_out;
      logic        data_oe;
   } snap_t;

   typedef struct {
      int    cyc;
      string name;
      snap_t mask;
      snap_t val;
   } entry_t;

   entry_t q[$];
   snap_t  act;
   snap_t  mdl = '0;
   snap_t  fm;
   snap_t  fv;
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;

   assign act = {freq, pw, control, adsr, fc, res_filt, mode_vol,
                 gate_rise, gate_fall, data_out, data_oe};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_field(input int c, input string nm,
                             input snap_t m, input snap_t v);
      entry_t e;
      e.cyc  = c;
      e.name = nm;
      e.mask = m;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic push_snap(input int c, input string nm);
      push_field(c, nm, '1, mdl);
   endtask

   // reference register map
   task automatic mwrite(input logic [4:0] a, input logic [7:0] d);
      int v;
      int o;
      v = int'(a) / 7;
      o = int'(a) % 7;
      if (a < 5'd21) begin
         case (o)
            0: mdl.freq[16*v +: 8]   = d;
            1: mdl.freq[16*v+8 +: 8] = d;
            2: mdl.pw[12*v +: 8]     = d;
            3: mdl.pw[12*v+8 +: 4]   = d[3:0];
            4: begin
               mdl.gate_rise[v] = d[0] & ~mdl.control[8*v];
               mdl.gate_fall[v] = ~d[0] & mdl.control[8*v];
               mdl.control[8*v +: 8] = d;
            end
            5: mdl.adsr[16*v+8 +: 8] = d;
            6: mdl.adsr[16*v +: 8]   = d;
            default: ;
         endcase
      end else begin
         case (a)
            5'h15: mdl.fc[2:0]  = d[2:0];
            5'h16: mdl.fc[10:3] = d;
            5'h17: mdl.res_filt = d;
            5'h18: mdl.mode_vol = d;
            default: ;
         endcase
      end
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [7:0] d,
                            input string nm, input bit abort = 1'b0,
                            input bit use_f = 1'b0);
      int n;
      @(negedge clk);
      cs_n = 1'b0; rw = 1'b0; addr = a; data_in = d;
      @(negedge clk);
      phi2 = 1'b1;
      repeat (3) @(negedge clk);
      if (abort) cs_n = 1'b1;
      repeat (4) @(negedge clk);
      phi2 = 1'b0;
      n = cyc;
      push_snap(n + S, {nm, "_early"});
      if (!abort) mwrite(a, d);
      push_snap(n + S + 1, nm);
      if (use_f) push_field(n + S + 1, {nm, "_hand"}, fm, fv);
      mdl.gate_rise = '0;
      mdl.gate_fall = '0;
      push_snap(n + S + 2, {nm, "_after"});
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
   endtask

   task automatic bus_read(input logic [4:0] a, input logic [7:0] exp,
                           input string nm);
      int n;
      @(negedge clk);
      cs_n = 1'b0; rw = 1'b1; addr = a;
      @(negedge clk);
      phi2 = 1'b1;
      n = cyc;
      push_snap(n + S, {nm, "_early"});
      mdl.data_out = exp;
      mdl.data_oe  = 1'b1;
      push_snap(n + S + 1, nm);
      repeat (7) @(negedge clk);
      phi2 = 1'b0;
      n = cyc;
      push_snap(n + S, {nm, "_hold"});
      mdl.data_oe = 1'b0;
      push_snap(n + S + 1, {nm, "_oe_off"});
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
   endtask

   // monitor: compare whenever a tagged cycle comes due
   entry_t me;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         me = q.pop_front();
         checks++;
         if (me.cyc < cyc) begin
            errors++;
            $display("FAIL %s: check missed, due cycle %0d now %0d",
                     me.name, me.cyc, cyc);
         end else if ((act & me.mask) !== (me.val & me.mask)) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     me.name, act & me.mask, me.val & me.mask, cyc);
         end
      end
   end

   entry_t le;
   initial begin
      int n;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      push_snap(cyc + 1, "reset_state");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      bus_write(5'h00, 8'h34, "freq_lo");
      fm = '0; fv = '0;
      fm.freq[15:0] = '1; fv.freq[15:0] = 16'h1234;
      bus_write(5'h01, 8'h12, "freq_hi", 1'b0, 1'b1);

      fm = '0; fv = '0;
      fm.gate_rise = '1; fm.gate_fall = '1; fv.gate_rise = 3'b010;
      bus_write(5'h0B, 8'h11, "v2_gate_on", 1'b0, 1'b1);
      fv.gate_rise = 3'b000; fv.gate_fall = 3'b010;
      bus_write(5'h0B, 8'h10, "v2_gate_off", 1'b0, 1'b1);
      fv.gate_fall = 3'b000;
      bus_write(5'h0B, 8'h10, "v2_gate_same", 1'b0, 1'b1);

      bus_write(5'h13, 8'hA9, "v3_ad");
      fm = '0; fv = '0;
      fm.adsr[47:32] = '1; fv.adsr[47:32] = 16'hA95C;
      bus_write(5'h14, 8'h5C, "v3_sr", 1'b0, 1'b1);
      fm = '0; fv = '0;
      fm.pw[23:12] = '1; fv.pw[23:12] = 12'hF00;
      bus_write(5'h0A, 8'hFF, "v2_pw_hi", 1'b0, 1'b1);

      bus_write(5'h15, 8'hFF, "fc_lo");
      fm = '0; fv = '0;
      fm.fc = '1; fv.fc = 11'h55F;
      bus_write(5'h16, 8'hAB, "fc_hi", 1'b0, 1'b1);
      bus_write(5'h17, 8'h5A, "res_filt");
      bus_write(5'h19, 8'hEE, "ro_write");

      env3 = 8'h80;
      bus_read(5'h1C, 8'h80, "rd_env3");
      pot_x = 8'h3C;
      bus_read(5'h19, 8'h3C, "rd_pot_x");
      bus_read(5'h05, 8'h3C, "rd_latch");

      bus_write(5'h18, 8'h0F, "mode_vol");
      bus_read(5'h18, 8'h0F, "rd_decay_early");
      repeat (3) @(negedge clk);
      bus_read(5'h18, 8'h00, "rd_decay_late");

      bus_write(5'h00, 8'h99, "abort_wr", 1'b1);
      bus_read(5'h1D, 8'h00, "rd_after_abort");

      // reset in the middle of a read access
      pot_y = 8'h5A;
      @(negedge clk);
      cs_n = 1'b0; rw = 1'b1; addr = 5'h1A;
      @(negedge clk);
      phi2 = 1'b1;
      n = cyc;
      mdl.data_out = 8'h5A;
      mdl.data_oe  = 1'b1;
      push_snap(n + S + 1, "rd_pot_y");
      repeat (5) @(negedge clk);
      rst = 1'b0;
      mdl = '0;
      push_snap(cyc + 1, "rst_mid_access");
      repeat (2) @(negedge clk);
      phi2 = 1'b0;
      repeat (2) @(negedge clk);
      cs_n = 1'b1;
      rst  = 1'b1;
      repeat (2) @(negedge clk);

      fm = '0; fv = '0;
      fm.control[7:0] = '1; fm.gate_rise = '1;
      fv.control[7:0] = 8'hC3; fv.gate_rise = 3'b001;
      bus_write(5'h04, 8'hC3, "post_rst_ctrl", 1'b0, 1'b1);

      repeat (10) @(negedge clk);
      while (q.size() > 0) begin
         le = q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: never compared, due cycle %0d", le.name, le.cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
